// File: rtl/multiplier_8bit_if.sv
// Button, switch and result signals between the multiplier and its surroundings.
// master drives buttons/switches; slave (the multiplier) drives the product registers and Busy.
interface multiplier_8bit_if;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] S;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       Busy;

    modport master (
        output Run, ClearA_LoadB, S,
        input  Aval, Bval, X, Busy
    );

    modport slave (
        input  Run, ClearA_LoadB, S,
        output Aval, Bval, X, Busy
    );
endinterface

// File: rtl/multiplier_8bit.sv
// Signed 8x8 add-shift multiplier; product in {A,B}, X is sign extension of A.
// Latency: SYNC_STAGES + 1 cycles from Run to Busy, Busy for 17 cycles; no backpressure.
module multiplier_8bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    multiplier_8bit_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] run_sync, clr_sync;
    logic                   run_s, clr_s;
    logic                   x_q, x_d;
    logic [7:0]             a_q, a_d;
    logic [7:0]             b_q, b_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic [8:0]             a_ext, s_ext, sum9, dif9;

    // Buttons idle high, so the synchronisers reset to the released level.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_sync <= '1;
            clr_sync <= '1;
        end else begin
            run_sync <= {run_sync[SYNC_STAGES-2:0], bus.Run};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], bus.ClearA_LoadB};
        end
    end

    assign run_s = run_sync[SYNC_STAGES-1];
    assign clr_s = clr_sync[SYNC_STAGES-1];

    // Nine-bit operands keep -128 * -128 from overflowing the partial product.
    assign a_ext = {a_q[7], a_q};
    assign s_ext = {bus.S[7], bus.S};
    assign sum9  = a_ext + s_ext;
    assign dif9  = a_ext - s_ext;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!clr_s) begin
                    b_d = bus.S;
                    a_d = 8'h00;
                    x_d = 1'b0;
                end else if (!run_s) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                a_d     = 8'h00;
                x_d     = 1'b0;
                cnt_d   = 3'd0;
                state_d = ADD;
            end
            ADD: begin
                // The last multiplier bit carries negative weight in two's complement.
                if (b_q[0]) begin
                    if (cnt_q == 3'd7) begin
                        {x_d, a_d} = dif9;
                    end else begin
                        {x_d, a_d} = sum9;
                    end
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d     = {x_q, a_q[7:1]};
                b_d     = {a_q[0], b_q[7:1]};
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd7) ? DONE : ADD;
            end
            DONE: begin
                if (run_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CLR) || (state_d == ADD) || (state_d == SHIFT);
    end

    assign bus.Aval = a_q;
    assign bus.Bval = b_q;
    assign bus.X    = x_q;
    assign bus.Busy = busy_q;

endmodule

// File: tb/tb_multiplier_8bit.sv
// Directed bench for multiplier_8bit: expected products queued at Run, compared at the first DONE cycle.
module tb_multiplier_8bit;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic [7:0]  model_b;
    logic [16:0] sb[$];

    multiplier_8bit_if bus ();

    multiplier_8bit #(.SYNC_STAGES(2)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] regs();
        return {bus.X, bus.Aval, bus.Bval};
    endfunction

    task automatic load_b(input logic [7:0] v);
        bus.S = v;
        bus.ClearA_LoadB = 1'b0;
        repeat (4) tick();
        bus.ClearA_LoadB = 1'b1;
        repeat (4) tick();
        model_b = v;
        check("load", 32'(regs()), {15'd0, 1'b0, 8'h00, v});
    endtask

    task automatic run_mult(input logic [7:0] s, input int hold, input bit pulse_clr);
        logic signed [15:0] ms, mb, p;
        logic [16:0] exp;
        int waited, n, extra;
        bus.S = s;
        ms = {{8{s[7]}}, s};
        mb = {{8{model_b[7]}}, model_b};
        p  = ms * mb;
        sb.push_back({p[15], p});
        bus.Run = 1'b0;
        waited = 0;
        while (!bus.Busy && waited < 10) begin
            tick();
            waited++;
        end
        check("busy_start", 32'(bus.Busy), 32'd1);
        n = 0;
        while (bus.Busy && n < 40) begin
            n++;
            if (pulse_clr && n == 3) bus.ClearA_LoadB = 1'b0;
            if (pulse_clr && n == 7) bus.ClearA_LoadB = 1'b1;
            tick();
        end
        check("busy_len", 32'(n), 32'd17);
        exp = sb.pop_front();
        check("product", 32'(regs()), 32'(exp));
        model_b = exp[7:0];
        extra = 0;
        for (int i = waited + n; i < hold; i++) begin
            tick();
            if (bus.Busy) extra++;
        end
        check("no_repeat", 32'(extra), 32'd0);
        bus.Run = 1'b1;
        repeat (4) tick();
        check("hold_after", 32'(regs()), 32'(exp));
    endtask

    initial begin
        int busy_seen;
        logic signed [15:0] p;
        tests = 0;
        fails = 0;
        model_b = 8'h00;
        rst_n = 1'b0;
        bus.Run = 1'b1;
        bus.ClearA_LoadB = 1'b1;
        bus.S = 8'h00;
        #1;
        check("reset_init", {14'd0, bus.Busy, regs()}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // 59 x 7, then -99 x 2 reusing the low product byte
        load_b(8'h07);
        run_mult(8'h3B, 30, 1'b0);
        run_mult(8'h02, 30, 1'b0);

        // -7 x 59 and the corner operands
        load_b(8'h3B);
        run_mult(8'hF9, 30, 1'b0);
        load_b(8'hFF);
        run_mult(8'hFF, 30, 1'b0);
        load_b(8'h80);
        run_mult(8'h80, 30, 1'b0);
        load_b(8'h80);
        run_mult(8'h01, 30, 1'b0);
        load_b(8'h5A);
        run_mult(8'hA3, 30, 1'b0);

        // Run held for 100 cycles starts exactly one multiplication
        load_b(8'h07);
        run_mult(8'h3B, 100, 1'b0);

        // ClearA_LoadB pulsed while Busy must be ignored
        load_b(8'h07);
        run_mult(8'h3B, 30, 1'b1);

        // Both buttons together: load wins, run starts after load released
        bus.S = 8'h05;
        bus.Run = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        busy_seen = 0;
        repeat (6) begin
            tick();
            if (bus.Busy) busy_seen++;
        end
        check("both_no_busy", 32'(busy_seen), 32'd0);
        check("both_load", 32'(regs()), 32'h00005);
        model_b = 8'h05;
        bus.ClearA_LoadB = 1'b1;
        run_mult(8'h05, 30, 1'b0);

        // Asynchronous reset while idle
        load_b(8'h07);
        #2 rst_n = 1'b0;
        #1;
        check("reset_idle", {14'd0, bus.Busy, regs()}, 32'd0);
        tick();
        rst_n = 1'b1;
        model_b = 8'h00;
        repeat (2) tick();

        // Asynchronous reset at the fifth Busy cycle
        load_b(8'h07);
        bus.S = 8'h3B;
        p = 16'sd413;
        sb.push_back({p[15], p});
        bus.Run = 1'b0;
        for (int i = 0; i < 10 && !bus.Busy; i++) tick();
        check("busy_before_rst", 32'(bus.Busy), 32'd1);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", {14'd0, bus.Busy, regs()}, 32'd0);
        void'(sb.pop_front());
        bus.Run = 1'b1;
        tick();
        rst_n = 1'b1;
        model_b = 8'h00;
        busy_seen = 0;
        repeat (8) begin
            tick();
            if (bus.Busy) busy_seen++;
        end
        check("idle_after_rst", 32'(busy_seen), 32'd0);

        // Machine still usable after the abort
        load_b(8'h07);
        run_mult(8'h3B, 30, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
